// File: rtl/timing_pkg.sv
// Shared types and defaults for the timing-error recovery block.
package timing_pkg;
   typedef enum logic [1:0] {RUN, STALL, FAIL} state_t;

   localparam int COUNT_W           = 16;
   localparam int W_DEF             = 8;
   localparam int STALL_CYC_DEF     = 1;
   localparam int ERR_LIMIT_DEF     = 4;
endpackage

// File: rtl/timing_err_recovery_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   logic sat;
   assign sat = &count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && !sat)
         count <= count + 1'b1;
   end
endmodule

// File: rtl/timing_err_recovery.sv
// Razor-style capture monitor: forwards shadow data on mismatch, stalls upstream,
// and gives up (sticky fail) after ERR_LIMIT consecutive corrected errors.
module timing_err_recovery
   import timing_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int STALL_CYC = STALL_CYC_DEF,
   parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [W-1:0]       main_d,
   input  logic [W-1:0]       shadow_d,
   input  logic               err_clr,
   output logic [W-1:0]       out_data,
   output logic               out_valid,
   output logic               stall,
   output logic               err_pulse,
   output logic [COUNT_W-1:0] err_count,
   output logic               fail
);
   localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 1);
   localparam logic [3:0] LIMIT      = 4'(ERR_LIMIT);

   state_t     state;
   logic [3:0] cons_cnt;
   logic [3:0] stall_cnt;
   logic [3:0] cons_nxt;
   logic       mismatch;
   logic       err_inc;

   assign mismatch = (main_d != shadow_d);
   assign cons_nxt = cons_cnt + 4'd1;
   // Clear beats a same-cycle mismatch, so the count only moves when err_clr is low.
   assign err_inc  = !err_clr && (state == RUN) && in_valid && mismatch;

   sat_counter #(.WIDTH(COUNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .clr   (err_clr),
      .count (err_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         cons_cnt  <= '0;
         stall_cnt <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         stall     <= 1'b0;
         err_pulse <= 1'b0;
         fail      <= 1'b0;
      end else if (err_clr) begin
         state     <= RUN;
         cons_cnt  <= '0;
         stall_cnt <= '0;
         out_valid <= 1'b0;
         stall     <= 1'b0;
         err_pulse <= 1'b0;
         fail      <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               err_pulse <= 1'b0;
               out_valid <= in_valid;
               stall     <= 1'b0;
               if (in_valid) begin
                  if (!mismatch) begin
                     out_data <= main_d;
                     cons_cnt <= '0;
                  end else begin
                     out_data  <= shadow_d;
                     err_pulse <= 1'b1;
                     stall     <= 1'b1;
                     cons_cnt  <= cons_nxt;
                     if (cons_nxt == LIMIT) begin
                        state <= FAIL;
                        fail  <= 1'b1;
                     end else begin
                        state     <= STALL;
                        stall_cnt <= STALL_LOAD;
                     end
                  end
               end
            end
            // The corrected-sample cycle is the first stall cycle.
            STALL: begin
               out_valid <= 1'b0;
               err_pulse <= 1'b0;
               if (stall_cnt == 4'd0) begin
                  state <= RUN;
                  stall <= 1'b0;
               end else begin
                  stall_cnt <= stall_cnt - 4'd1;
               end
            end
            FAIL: begin
               out_valid <= 1'b0;
               err_pulse <= 1'b0;
               stall     <= 1'b1;
               fail      <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_timing_err_recovery.sv
// Two instances (STALL_CYC 1 and 3) on shared inputs, checked against a cycle-level model.
module tb_timing_err_recovery;
   localparam int LIMIT = 4;

   typedef struct {
      int         stall_left;
      bit         failed;
      int         cons;
      int         cnt;
      logic [7:0] data;
      bit         ov;
      bit         pulse;
      bit         stl;
   } mdl_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  main_d, shadow_d;
   logic        err_clr;
   logic [7:0]  od [2];
   logic        ov [2];
   logic        st [2];
   logic        ep [2];
   logic [15:0] ec [2];
   logic        fl [2];

   int   checks = 0;
   int   errors = 0;
   mdl_t m [2];
   int   sc [2] = '{1, 3};

   always #5 clk = ~clk;

   timing_err_recovery #(.W(8), .STALL_CYC(1), .ERR_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .main_d(main_d), .shadow_d(shadow_d),
      .err_clr(err_clr), .out_data(od[0]), .out_valid(ov[0]), .stall(st[0]),
      .err_pulse(ep[0]), .err_count(ec[0]), .fail(fl[0])
   );

   timing_err_recovery #(.W(8), .STALL_CYC(3), .ERR_LIMIT(LIMIT)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .main_d(main_d), .shadow_d(shadow_d),
      .err_clr(err_clr), .out_data(od[1]), .out_valid(ov[1]), .stall(st[1]),
      .err_pulse(ep[1]), .err_count(ec[1]), .fail(fl[1])
   );

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.stall_left = 0; n.failed = 0; n.cons = 0; n.cnt = 0;
      n.data = 8'h00; n.ov = 0; n.pulse = 0; n.stl = 0;
      return n;
   endfunction

   // Predicts the outputs visible after the next rising edge.
   function automatic mdl_t step(mdl_t cur, int scyc, logic v, logic [7:0] md, logic [7:0] sd,
                                 logic c);
      mdl_t n = cur;
      n.pulse = 0;
      n.ov    = 0;
      if (c) begin
         n.cnt = 0; n.cons = 0; n.failed = 0; n.stall_left = 0; n.stl = 0;
      end else if (cur.failed) begin
         n.stl = 1;
      end else if (cur.stall_left > 0) begin
         n.stall_left = cur.stall_left - 1;
         n.stl = (n.stall_left > 0);
      end else begin
         n.stl = 0;
         if (v) begin
            n.ov = 1;
            if (md == sd) begin
               n.data = md;
               n.cons = 0;
            end else begin
               n.data  = sd;
               n.pulse = 1;
               if (cur.cnt < 65535) n.cnt = cur.cnt + 1;
               n.cons = cur.cons + 1;
               n.stl  = 1;
               if (n.cons >= LIMIT) n.failed = 1;
               else n.stall_left = scyc;
            end
         end
      end
      return n;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_inst(int i, mdl_t e);
      string p;
      p = (i == 0) ? "s1" : "s3";
      chk({p, ".out_valid"}, 32'(ov[i]), 32'(e.ov));
      if (e.ov) chk({p, ".out_data"}, 32'(od[i]), 32'(e.data));
      chk({p, ".stall"},     32'(st[i]), 32'(e.stl));
      chk({p, ".err_pulse"}, 32'(ep[i]), 32'(e.pulse));
      chk({p, ".err_count"}, 32'(ec[i]), 32'(e.cnt));
      chk({p, ".fail"},      32'(fl[i]), 32'(e.failed));
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) check_inst(i, m[i]);
   endtask

   task automatic drive(logic v, logic [7:0] md, logic [7:0] sd, logic c);
      @(negedge clk);
      check_all();
      in_valid = v; main_d = md; shadow_d = sd; err_clr = c;
      for (int i = 0; i < 2; i++) m[i] = step(m[i], sc[i], v, md, sd, c);
   endtask

   initial begin
      mdl_t z;
      logic [7:0] a, b;
      logic       v, c;
      z = mdl_reset();
      rst_n = 1'b0; in_valid = 0; main_d = 0; shadow_d = 0; err_clr = 0;
      for (int i = 0; i < 2; i++) m[i] = mdl_reset();
      #7;
      check_all();
      chk("reset.out_data", 32'(od[0]), 32'h0);
      #5 rst_n = 1'b1;

      // match, then single mismatch with stall
      drive(1, 8'h5A, 8'h5A, 0);
      drive(1, 8'h3C, 8'h3D, 0);
      for (int i = 0; i < 4; i++) drive(0, 8'h00, 8'h00, 0);

      // consecutive errors to fail, then clear
      for (int k = 0; k < 4; k++) begin
         drive(1, 8'(8'h10 + k), 8'(8'h90 + k), 0);
         for (int i = 0; i < 3; i++) drive(0, 8'h00, 8'h00, 0);
      end
      drive(1, 8'h11, 8'h22, 0);
      drive(0, 8'h00, 8'h00, 1);
      drive(0, 8'h00, 8'h00, 0);

      // saturation near the top of the error counter (first instance only)
      force dut.u_err_cnt.count = 16'hFFFE;
      #1 release dut.u_err_cnt.count;
      m[0].cnt = 16'hFFFE;
      drive(1, 8'hA0, 8'hA1, 0);
      for (int i = 0; i < 3; i++) drive(0, 8'h00, 8'h00, 0);
      drive(1, 8'h77, 8'h77, 0);
      drive(1, 8'hB0, 8'hB2, 0);
      for (int i = 0; i < 3; i++) drive(0, 8'h00, 8'h00, 0);

      // clear wins over a same-cycle mismatch
      drive(1, 8'h01, 8'h02, 1);
      drive(0, 8'h00, 8'h00, 0);

      // asynchronous reset mid-stall, then latency-1 sample
      drive(1, 8'hC3, 8'hC4, 0);
      drive(0, 8'h00, 8'h00, 0);
      @(negedge clk);
      check_all();
      in_valid = 1; main_d = 8'h66; shadow_d = 8'h66; err_clr = 0;
      chk("pre_reset.s3.stall", 32'(st[1]), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, z);
      chk("reset.s3.out_data", 32'(od[1]), 32'h0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) m[i] = step(mdl_reset(), sc[i], 1, 8'h66, 8'h66, 0);
      drive(0, 8'h00, 8'h00, 0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         v = ($urandom_range(0, 9) < 8);
         a = 8'($urandom);
         b = ($urandom_range(0, 1) == 1) ? (a ^ 8'($urandom_range(1, 255))) : a;
         c = ($urandom_range(0, 29) == 0);
         drive(v, a, b, c);
      end
      @(negedge clk);
      check_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
